matrix_scroll_scan: RTL



---
 rtl/matrix_scroll_scan.sv | 110 +++++++++++
 1 files changed

// File: rtl/matrix_scroll_scan.sv
// Scrolling-text driver for an 8x8 LED matrix: fetches glyphs, shifts their
// columns into an 8-column window and time-multiplexes that window onto the matrix.
module matrix_scroll_scan #(
  parameter int SCROLL_DIV = 200000,
  parameter int SCAN_DIV   = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] msg_len,
  input  logic [5:0] msg_data,
  input  logic       pause,
  input  logic [7:0] col0,
  input  logic [7:0] col1,
  input  logic [7:0] col2,
  input  logic [7:0] col3,
  input  logic [7:0] col4,
  input  logic [7:0] col5,
  input  logic [7:0] col6,
  output logic [4:0] msg_addr,
  output logic [5:0] char_code,
  output logic [7:0] scan_sel,
  output logic [7:0] scan_row
);
  localparam int SCW = $clog2(SCROLL_DIV);
  localparam int SNW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_DIV - 1);
  localparam logic [SNW-1:0] SCAN_LAST   = SNW'(SCAN_DIV - 1);
  localparam logic [5:0] BLANK = 6'h24;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  logic [1:0]       state;
  logic [4:0]       char_idx;
  logic [2:0]       col_idx;
  logic [7:0][7:0]  win;
  logic [6:0][7:0]  gbuf;
  logic [6:0][7:0]  cols;
  logic [SCW-1:0]   scroll_cnt;
  logic [SNW-1:0]   scan_cnt;
  logic [2:0]       scan_idx;
  logic             tick;
  logic [5:0]       idx_inc;

  assign cols     = {col6, col5, col4, col3, col2, col1, col0};
  assign tick     = !pause && (scroll_cnt == SCROLL_LAST);
  assign idx_inc  = {1'b0, char_idx} + 6'd1;
  assign msg_addr = char_idx;

  // Pause freezes the scroll phase so scrolling resumes exactly where it stopped.
  always_ff @(posedge clk) begin
    if (rst)
      scroll_cnt <= '0;
    else if (!pause)
      scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      char_idx  <= '0;
      col_idx   <= '0;
      win       <= '0;
      gbuf      <= '0;
      char_code <= BLANK;
    end else begin
      case (state)
        S_FETCH: begin
          char_code <= (msg_len == 5'd0) ? BLANK : msg_data;
          state     <= S_WAIT;
        end
        S_WAIT:    state <= S_CAPTURE;
        S_CAPTURE: begin
          gbuf  <= cols;
          state <= S_RUN;
        end
        default: begin
          if (tick) begin
            // Window scrolls left: oldest column drops out of win[0].
            win <= {gbuf[col_idx], win[7:1]};
            if (col_idx == 3'd6) begin
              col_idx  <= '0;
              char_idx <= (idx_inc >= {1'b0, msg_len}) ? 5'd0 : idx_inc[4:0];
              state    <= S_FETCH;
            end else begin
              col_idx <= col_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      scan_sel <= 8'h00;
      scan_row <= 8'h00;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      if (scan_cnt == SCAN_LAST)
        scan_idx <= scan_idx + 3'd1;
      scan_sel <= 8'h01 << scan_idx;
      scan_row <= win[scan_idx];
    end
  end
endmodule
